// File: rtl/tbird_pkg.sv
// rtl/tbird_pkg.sv - shared types and helpers for the tail-light sequencer
//
// Purpose: state encoding shared by the sequencer and its bench-side
// interface, plus the hazard-request decode used in several transitions.
package tbird_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEFT    = 3'd1,
    ST_RIGHT   = 3'd2,
    ST_HAZ_ON  = 3'd3,
    ST_HAZ_OFF = 3'd4
  } t_tbird_seq_state;

  // Both turn requests at once are treated exactly like a hazard request.
  function automatic logic hazard_req(input logic haz, input logic left,
                                      input logic right);
    return haz | (left & right);
  endfunction

endpackage

// File: rtl/tbird_seq_if.sv
// rtl/tbird_seq_if.sv - request/lamp bundle for the tail-light sequencer
//
// Purpose: groups the request levels, step divisor and lamp outputs.
// Ports (signals):
//   left/right/haz/brake : request levels toward the sequencer
//   step_div             : step period minus one, in clocks
//   l_lights/r_lights    : lamp outputs, bit 0 innermost
//   busy                 : sequencer not idle
// Modports: master drives requests, slave is the sequencer side.
interface tbird_seq_if #(
  parameter int N_LAMPS = 3,
  parameter int DIV_W   = 4
);
  logic               left;
  logic               right;
  logic               haz;
  logic               brake;
  logic [DIV_W-1:0]   step_div;
  logic [N_LAMPS-1:0] l_lights;
  logic [N_LAMPS-1:0] r_lights;
  logic               busy;

  modport master (
    output left, right, haz, brake, step_div,
    input  l_lights, r_lights, busy
  );

  modport slave (
    input  left, right, haz, brake, step_div,
    output l_lights, r_lights, busy
  );
endinterface

// File: rtl/tbird_tick_div.sv
// rtl/tbird_tick_div.sv - step-rate divider producing the sequencer tick
//
// Purpose: counts clocks and raises tick once the count reaches step_div.
// Ports:
//   clk, rst_b : clock, asynchronous active-low reset
//   clr        : hold the count at zero
//   step_div   : step period minus one (0 = tick every clock)
//   tick       : step strobe, combinational from count and step_div
module tbird_tick_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clr,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // Compare with >= so that lowering step_div below the running count
  // produces an immediate tick instead of a wrap through the full range.
  assign tick = (count_q >= step_div);

  always_comb begin
    count_d = count_q + DIV_W'(1);
    if (clr || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tbird_seq.sv
// rtl/tbird_seq.sv - Thunderbird-style tail-light sequencer
//
// Purpose: sequences turn lamps as a growing thermometer, flashes hazards,
// and overlays brake on the non-sequencing side(s).
// Ports:
//   clk, rst_b          : clock, asynchronous active-low reset
//   left/right/haz/brake: request levels
//   step_div            : step period minus one, in clocks
//   l_lights/r_lights   : lamps per side, bit 0 innermost
//   busy                : high whenever the sequencer is not idle
module tbird_seq
  import tbird_pkg::*;
#(
  parameter int N_LAMPS = 3,
  parameter int DIV_W   = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               left,
  input  logic               right,
  input  logic               haz,
  input  logic               brake,
  input  logic [DIV_W-1:0]   step_div,
  output logic [N_LAMPS-1:0] l_lights,
  output logic [N_LAMPS-1:0] r_lights,
  output logic               busy
);

  localparam int POS_W = $clog2(N_LAMPS + 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LAMPS);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  t_tbird_seq_state   state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               tick;
  logic               div_clr;
  logic               hz;
  logic               own_req;
  logic [N_LAMPS-1:0] seq_mask;

  // Divider is parked at zero while idle so every sequence starts with a
  // full step period after leaving IDLE.
  assign div_clr = (state_q == ST_IDLE);

  tbird_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk      (clk),
    .rst_b    (rst_b),
    .clr      (div_clr),
    .step_div (step_div),
    .tick     (tick)
  );

  assign hz      = hazard_req(haz, left, right);
  assign own_req = (state_q == ST_LEFT) ? left : right;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    case (state_q)
      // IDLE reacts on the first clock a request is seen, not on a tick.
      ST_IDLE: begin
        pos_d = '0;
        if (hz) begin
          state_d = ST_HAZ_ON;
        end else if (left) begin
          state_d = ST_LEFT;
          pos_d   = POS_ONE;
        end else if (right) begin
          state_d = ST_RIGHT;
          pos_d   = POS_ONE;
        end
      end
      // The opposite single request is never looked at here; only a
      // hazard can interrupt a running sequence.
      ST_LEFT, ST_RIGHT: begin
        if (tick) begin
          if (hz) begin
            state_d = ST_HAZ_ON;
            pos_d   = '0;
          end else if (pos_q < POS_MAX) begin
            pos_d = pos_q + POS_ONE;
          end else if (own_req) begin
            pos_d = '0;
          end else begin
            state_d = ST_IDLE;
            pos_d   = '0;
          end
        end
      end
      ST_HAZ_ON: begin
        if (tick) begin
          state_d = ST_HAZ_OFF;
        end
      end
      ST_HAZ_OFF: begin
        if (tick) begin
          state_d = hz ? ST_HAZ_ON : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pos_d   = '0;
      end
    endcase
  end

  // Thermometer: the lowest pos lamps are lit.
  always_comb begin
    seq_mask = '0;
    for (int i = 0; i < N_LAMPS; i++) begin
      seq_mask[i] = (POS_W'(i) < pos_q);
    end
  end

  // Lamps depend only on state, pos and brake so request glitches never
  // reach the lamps between ticks.
  always_comb begin
    l_lights = '0;
    r_lights = '0;
    busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (brake) begin
          l_lights = '1;
          r_lights = '1;
        end
      end
      ST_LEFT: begin
        l_lights = seq_mask;
        if (brake) begin
          r_lights = '1;
        end
      end
      ST_RIGHT: begin
        r_lights = seq_mask;
        if (brake) begin
          l_lights = '1;
        end
      end
      ST_HAZ_ON: begin
        l_lights = '1;
        r_lights = '1;
      end
      default: begin
        l_lights = '0;
        r_lights = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tbird_seq.sv
// tb/tb_tbird_seq.sv - scoreboard bench for the tail-light sequencer
module tb_tbird_seq;

  localparam int N   = 3;
  localparam int DW  = 4;
  localparam int ALL = (1 << N) - 1;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  tbird_seq_if #(.N_LAMPS(N), .DIV_W(DW)) bus();

  tbird_seq #(.N_LAMPS(N), .DIV_W(DW)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .left     (bus.left),
    .right    (bus.right),
    .haz      (bus.haz),
    .brake    (bus.brake),
    .step_div (bus.step_div),
    .l_lights (bus.l_lights),
    .r_lights (bus.r_lights),
    .busy     (bus.busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [2*N:0] exp_q[$];

  // Reference model: active flag, which side (0 left, 1 right, 2 hazard),
  // hazard lamps lit, lamp count and clocks since last step.
  bit m_active;
  int m_side;
  bit m_lit;
  int m_pos;
  int m_cnt;

  function automatic void model_reset();
    m_active = 0;
    m_side   = 0;
    m_lit    = 0;
    m_pos    = 0;
    m_cnt    = 0;
  endfunction

  function automatic logic [2*N:0] expected();
    int l, r;
    logic [N-1:0] lv, rv;
    bit b;
    l = 0;
    r = 0;
    b = m_active;
    if (!m_active) begin
      l = bus.brake ? ALL : 0;
      r = l;
    end else if (m_side == 2) begin
      l = m_lit ? ALL : 0;
      r = l;
    end else if (m_side == 0) begin
      l = (1 << m_pos) - 1;
      r = bus.brake ? ALL : 0;
    end else begin
      r = (1 << m_pos) - 1;
      l = bus.brake ? ALL : 0;
    end
    lv = l[N-1:0];
    rv = r[N-1:0];
    return {b, lv, rv};
  endfunction

  function automatic void model_step();
    bit hz, tick, own;
    if (!rst_b) begin
      model_reset();
      return;
    end
    hz = bus.haz || (bus.left && bus.right);
    if (!m_active) begin
      m_cnt = 0;
      if (hz) begin
        m_active = 1; m_side = 2; m_lit = 1; m_pos = 0;
      end else if (bus.left) begin
        m_active = 1; m_side = 0; m_pos = 1;
      end else if (bus.right) begin
        m_active = 1; m_side = 1; m_pos = 1;
      end
      return;
    end
    tick  = (m_cnt >= int'(bus.step_div));
    m_cnt = tick ? 0 : m_cnt + 1;
    if (!tick) return;
    if (m_side == 2) begin
      if (m_lit) m_lit = 0;
      else if (hz) m_lit = 1;
      else m_active = 0;
    end else begin
      own = (m_side == 0) ? bus.left : bus.right;
      if (hz) begin
        m_side = 2; m_lit = 1; m_pos = 0;
      end else if (m_pos < N) begin
        m_pos++;
      end else if (own) begin
        m_pos = 0;
      end else begin
        m_active = 0; m_pos = 0;
      end
    end
  endfunction

  // Monitor: compares the DUT against queued expectations mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [2*N:0] e, got;
      e   = exp_q.pop_front();
      got = {bus.busy, bus.l_lights, bus.r_lights};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL sb cyc=%0d busy/l/r got=%b_%b_%b exp=%b_%b_%b", cyc,
                 got[2*N], got[2*N-1:N], got[N-1:0], e[2*N], e[2*N-1:N], e[N-1:0]);
      end
    end
  end

  // One clock: model follows the edge, expectation queued, inputs may be
  // changed by the caller once this returns (after the monitor sample).
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      exp_q.push_back(expected());
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_now(input string name);
    logic [2*N:0] e, got;
    e   = expected();
    got = {bus.busy, bus.l_lights, bus.r_lights};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, e);
    end
  endtask

  task automatic run_until(input int side, input int pos, input string name);
    int k;
    k = 0;
    while (!(m_active && m_side == side && m_pos == pos) && k < 40) begin
      run(1);
      k++;
    end
    checks++;
    if (k >= 40) begin
      errors++;
      $display("FAIL %s timeout waiting side=%0d pos=%0d", name, side, pos);
    end
  endtask

  task automatic run_until_idle(input string name);
    int k;
    k = 0;
    while (m_active && k < 60) begin
      run(1);
      k++;
    end
    run(1);
    checks++;
    if (k >= 60) begin
      errors++;
      $display("FAIL %s timeout waiting for idle", name);
    end
  endtask

  initial begin
    rst_b        = 1'b0;
    bus.left     = 1'b0;
    bus.right    = 1'b0;
    bus.haz      = 1'b0;
    bus.brake    = 1'b0;
    bus.step_div = DW'(1);
    model_reset();
    run(2);
    check_now("reset_state");
    bus.brake = 1'b1;
    #1;
    check_now("reset_brake");
    bus.brake = 1'b0;
    rst_b = 1'b1;
    run(2);

    // Left held: 001 at once, then stepping every two clocks with wrap.
    bus.left = 1'b1;
    run(12);
    // Left dropped at 011: finishes to 111 then idles.
    run_until(0, 2, "left_011");
    bus.left = 1'b0;
    run_until_idle("left_drop");
    check_now("left_drop_idle");

    // Hazard raised while right shows 011.
    bus.right = 1'b1;
    run_until(1, 2, "right_011");
    bus.right = 1'b0;
    bus.haz   = 1'b1;
    run(9);
    run_until(2, 0, "haz_seen");
    while (!m_lit) run(1);
    bus.haz = 1'b0;
    run_until_idle("haz_drop");

    // Brake during a left sequence, then brake alone in IDLE.
    bus.brake = 1'b1;
    bus.left  = 1'b1;
    bus.right = 1'b1;
    bus.right = 1'b0;
    run(10);
    bus.left = 1'b0;
    run_until_idle("brake_left");
    run(2);
    bus.brake = 1'b0;
    run(1);

    // Both turn requests from IDLE, then fastest step rate.
    bus.left  = 1'b1;
    bus.right = 1'b1;
    run(1);
    bus.step_div = DW'(0);
    run(6);
    bus.left  = 1'b0;
    bus.right = 1'b0;
    run_until_idle("both_req");

    // Asynchronous reset with all lamps lit, between ticks.
    bus.step_div = DW'(1);
    bus.left     = 1'b1;
    run_until(0, 3, "left_111");
    rst_b = 1'b0;
    model_reset();
    #1;
    check_now("async_reset");
    run(2);
    rst_b = 1'b1;
    run(1);
    bus.left = 1'b0;
    run_until_idle("after_reset");

    // Randomized traffic including step_div changes and reset pulses.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) bus.left  = 1'($urandom);
      if ($urandom_range(0, 5) == 0) bus.right = 1'($urandom);
      if ($urandom_range(0, 15) == 0) bus.haz  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) bus.brake = 1'($urandom);
      if ($urandom_range(0, 20) == 0) bus.step_div = DW'($urandom_range(0, 3));
      rst_b = ($urandom_range(0, 99) != 0);
      run(1);
    end
    rst_b = 1'b1;
    run(2);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tbird_seq.md
TBIRD_SEQ -- requirements
Module: tbird_seq

Interface
REQ-001 SHALL have parameter N_LAMPS, default 3, lamps per side (legal 2..8).
REQ-002 SHALL have parameter DIV_W, default 4, width of step-rate divisor.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_b  input  1  asynchronous active-low reset.
REQ-005 SHALL have port left  input  1  left-turn request, level.
REQ-006 SHALL have port right  input  1  right-turn request, level.
REQ-007 SHALL have port haz  input  1  hazard request, level.
REQ-008 SHALL have port brake  input  1  brake request, level.
REQ-009 SHALL have port step_div  input  DIV_W  step period minus one, in clocks.
REQ-010 SHALL have port l_lights  output  N_LAMPS  left lamps, bit 0 innermost.
REQ-011 SHALL have port r_lights  output  N_LAMPS  right lamps, bit 0 innermost.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL have states IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF, plus position counter pos, range 0..N_LAMPS.
REQ-014 SHALL generate step tick: divider counts clocks, tick when count >= step_div, count then clears; step_div=0 gives a tick every clock.
REQ-015 SHALL hold divider count at 0 while in IDLE.
REQ-016 SHALL leave IDLE on the first clock a request is present, not tick-gated: haz or (left&right) -> HAZ_ON; else left -> LEFT pos=1; else right -> RIGHT pos=1.
REQ-017 SHALL perform all non-IDLE transitions on tick only; no state or pos change between ticks.
REQ-018 SHALL, in LEFT/RIGHT on tick: haz or (left&right) -> HAZ_ON; else pos<N_LAMPS -> pos+1; else pos=N_LAMPS -> pos=0 same state if own request still high, otherwise IDLE.
REQ-019 SHALL, in LEFT/RIGHT, ignore the opposite single request until the sequence returns to IDLE.
REQ-020 SHALL, on tick, go HAZ_ON -> HAZ_OFF unconditionally; HAZ_OFF -> HAZ_ON if haz or (left&right), else IDLE.
REQ-021 SHALL drive sequencing side as thermometer: lowest pos bits set (pos=0 all dark, pos=N_LAMPS all lit).
REQ-022 SHALL drive both sides all ones in HAZ_ON, all zeros in HAZ_OFF; brake ignored in hazard states.
REQ-023 SHALL, with brake high in IDLE/LEFT/RIGHT, drive every non-sequencing side all ones; sequencing side unaffected.
REQ-024 SHALL drive outputs combinationally from state, pos, brake only; no dependency on left/right/haz.
REQ-025 SHALL treat a step_div change mid-count per REQ-014 (immediate tick if count already >= new value).

Reset
REQ-026 SHALL, on rst_b low, asynchronously force state IDLE, pos 0, divider count 0; outputs 0 unless brake high (then both sides all ones).
REQ-027 SHALL, on reset mid-sequence or mid-hazard, abandon the sequence with no residual lamp state; first clock after release re-evaluates per REQ-016.

Structure
REQ-028 SHALL place state enum t_tbird_seq_state in shared package tbird_pkg.
REQ-029 SHALL implement divider as sub-module tbird_tick_div (clk, rst_b, clr, step_div, tick).

Verification (N_LAMPS=3, step_div=1 -> tick every 2 clocks)
REQ-030 SHALL check left held: l_lights 001 immediately, then 011, 111, 000, 001 every 2 clocks; r_lights 000 throughout.
REQ-031 SHALL check left dropped at l_lights=011: continues 111, then IDLE (000), busy low.
REQ-032 SHALL check haz asserted at r_lights=011: next tick both 111, then 000, alternating; haz low during HAZ_ON -> HAZ_OFF then IDLE.
REQ-033 SHALL check brake high during left sequence: r_lights 111 constant, l_lights sequence unchanged; brake in IDLE -> both 111, busy low.
REQ-034 SHALL check left&right together from IDLE: HAZ_ON (111/111) same clock; step_div=0 alternates every clock.
REQ-035 SHALL check rst_b low at l_lights=111 mid-tick: outputs 000 without clock edge, busy low, restart gives 001.
